// File: rtl/event_sink_collector.sv
// Event sink collector: buffers incoming {addr, value} events in a small FIFO
// and drains them into a single-port result memory. Readback requests take
// the memory port ahead of the drain. A clear sequence zeroes the whole
// memory after reset or on request.
module event_sink_collector #(
  parameter int DATA_WIDTH = 22,
  parameter int FIFO_DEPTH = 16,
  parameter int MEM_DEPTH  = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_event_valid,
  input  logic [DATA_WIDTH-1:0] in_event_value,
  input  logic [15:0]           in_event_addr,
  output logic                  ready_for_new_event,
  input  logic                  rd_en,
  input  logic [15:0]           rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  clr,
  output logic                  clear_busy,
  output logic [31:0]           event_count,
  output logic                  overflow_err
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int MAW = $clog2(MEM_DEPTH);
  localparam int EW  = 16 + DATA_WIDTH;
  // The ring buffer keeps one slot free, so it holds FIFO_DEPTH-1 events.
  // Ready drops early enough that the one event already in flight when the
  // upstream sees ready fall still finds a free slot.
  localparam logic [FAW:0] FIFO_CAP  = (FAW+1)'(FIFO_DEPTH - 1);
  localparam logic [FAW:0] READY_MAX = (FAW+1)'(FIFO_DEPTH - 3);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state, state_next;
  logic [MAW-1:0]          clr_ptr;
  logic [EW-1:0]           fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0]          wr_ptr, rd_ptr;
  logic [FAW:0]            fifo_count, count_next;
  logic                    fifo_empty, fifo_full;
  logic                    push, pop, flush, do_read;
  logic                    mem_we;
  logic [MAW-1:0]          mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [EW-1:0]           head;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FIFO_CAP);
  assign head       = fifo_mem[rd_ptr];
  assign clear_busy = (state == CLEAR);

  // Next-state logic and arbitration of the single memory port.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    flush      = 1'b0;
    do_read    = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = clr_ptr;
    mem_wdata  = '0;
    case (state)
      CLEAR: begin
        mem_we = 1'b1;
        if (clr_ptr == MAW'(MEM_DEPTH - 1)) state_next = RUN;
      end
      RUN: begin
        if (clr) begin
          state_next = CLEAR;
          flush      = 1'b1;
        end else if (rd_en) begin
          do_read = 1'b1;
        end else if (!fifo_empty) begin
          pop       = 1'b1;
          mem_we    = 1'b1;
          mem_waddr = head[DATA_WIDTH +: MAW];
          mem_wdata = head[DATA_WIDTH-1:0];
        end
      end
      default: state_next = CLEAR;
    endcase
    push       = in_event_valid && !flush && (!fifo_full || pop);
    count_next = fifo_count + (FAW+1)'(push) - (FAW+1)'(pop);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_next;
  end

  // Clear pointer walks the memory while clearing and rests at zero otherwise.
  always_ff @(posedge clk) begin
    if (rst || state == RUN) clr_ptr <= '0;
    else                     clr_ptr <= clr_ptr + 1'b1;
  end

  // FIFO pointers and occupancy; a clear request discards queued events.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_next;
    end
  end

  // FIFO storage, written on every accepted event.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {in_event_addr, in_event_value};
  end

  // Registered ready based on the occupancy this cycle leaves behind.
  always_ff @(posedge clk) begin
    if (rst) ready_for_new_event <= 1'b0;
    else     ready_for_new_event <= (state_next == RUN) && (count_next <= READY_MAX);
  end

  // Saturating count of events written into memory.
  always_ff @(posedge clk) begin
    if (rst || flush)                     event_count <= '0;
    else if (pop && event_count != '1)    event_count <= event_count + 1'b1;
  end

  // Sticky flag for events that arrived with nowhere to go.
  always_ff @(posedge clk) begin
    if (rst || flush)                     overflow_err <= 1'b0;
    else if (in_event_valid && !push)     overflow_err <= 1'b1;
  end

  // Result memory write port, shared by the clear walk and the drain.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  // Readback returns data one cycle after the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= do_read;
      if (do_read) rd_data <= mem[rd_addr[MAW-1:0]];
    end
  end

endmodule

// File: tb/tb_event_sink_collector.sv
// Testbench for event_sink_collector with a queue-based reference model and
// a scoreboard for readback data.
module tb_event_sink_collector;

  localparam int DW  = 22;
  localparam int FD  = 16;
  localparam int MD  = 16;
  localparam int CAP = FD - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_event_valid = 1'b0;
  logic [DW-1:0] in_event_value = '0;
  logic [15:0]   in_event_addr = '0;
  logic          ready_for_new_event;
  logic          rd_en = 1'b0;
  logic [15:0]   rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          clr = 1'b0;
  logic          clear_busy;
  logic [31:0]   event_count;
  logic          overflow_err;

  event_sink_collector #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .MEM_DEPTH(MD)) dut (
    .clk(clk), .rst(rst),
    .in_event_valid(in_event_valid), .in_event_value(in_event_value),
    .in_event_addr(in_event_addr), .ready_for_new_event(ready_for_new_event),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr(clr), .clear_busy(clear_busy), .event_count(event_count),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]   addr;
    logic [DW-1:0] val;
  } ev_t;

  ev_t           m_fifo[$];
  logic [DW-1:0] m_mem [MD];
  logic [DW-1:0] exp_q[$];
  bit            m_clearing = 1'b0;
  int            m_clr_left = 0;
  bit            m_ready = 1'b0;
  bit            m_rdv = 1'b0;
  bit            m_ovf = 1'b0;
  logic [31:0]   m_cnt = '0;
  bit            chk_en = 1'b0;
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: events are a queue of limited capacity, memory is a
  // plain array, and each clock edge applies the rules for that cycle.
  always @(posedge clk) begin
    ev_t e;
    e = '{addr: in_event_addr, val: in_event_value};
    if (rst) begin
      chk_en     = 1'b1;
      m_clearing = 1'b1;
      m_clr_left = MD;
      m_fifo.delete();
      m_rdv = 1'b0;
      m_cnt = '0;
      m_ovf = 1'b0;
    end else if (m_clearing) begin
      m_mem[MD - m_clr_left] = '0;
      m_clr_left--;
      if (m_clr_left == 0) m_clearing = 1'b0;
      m_rdv = 1'b0;
      if (in_event_valid) begin
        if (m_fifo.size() < CAP) m_fifo.push_back(e);
        else                     m_ovf = 1'b1;
      end
    end else if (clr) begin
      m_clearing = 1'b1;
      m_clr_left = MD;
      m_fifo.delete();
      m_cnt = '0;
      m_ovf = 1'b0;
      m_rdv = 1'b0;
    end else begin
      m_rdv = rd_en;
      if (rd_en) begin
        exp_q.push_back(m_mem[int'(rd_addr) % MD]);
      end else if (m_fifo.size() > 0) begin
        ev_t d;
        d = m_fifo.pop_front();
        m_mem[int'(d.addr) % MD] = d.val;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
      if (in_event_valid) begin
        if (m_fifo.size() < CAP) m_fifo.push_back(e);
        else                     m_ovf = 1'b1;
      end
    end
    m_ready = !m_clearing && (m_fifo.size() <= FD - 3);
  end

  // Monitor: status outputs every cycle, read data whenever it is presented.
  always @(negedge clk) begin
    if (chk_en) begin
      check_val("ready", ready_for_new_event, m_ready);
      check_val("clear_busy", clear_busy, m_clearing);
      check_val("event_count", event_count, m_cnt);
      check_val("overflow_err", overflow_err, m_ovf);
      check_val("rd_valid", rd_valid, m_rdv);
      if (rd_valid || m_rdv) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL rd_data: got %0h with no expected entry", rd_data);
        end else begin
          logic [DW-1:0] x;
          x = exp_q.pop_front();
          if (rd_valid) check_val("rd_data", rd_data, x);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic v, input logic [15:0] a, input logic [DW-1:0] d,
                                input logic r, input logic [15:0] ra, input logic c,
                                input logic rs);
    @(negedge clk);
    in_event_valid = v;
    in_event_addr  = a;
    in_event_value = d;
    rd_en          = r;
    rd_addr        = ra;
    clr            = c;
    rst            = rs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 16'h0, '0, 0, 16'h0, 0, 0);
  endtask

  task automatic read_all();
    for (int i = 0; i < MD; i++) apply_stimulus(0, 16'h0, '0, 1, 16'(i), 0, 0);
    idle(2);
  endtask

  task automatic wait_clear_done(input string name);
    int n;
    n = 0;
    while (clear_busy && n < 100) begin
      idle(1);
      n++;
    end
    check_val(name, clear_busy, 1'b0);
  endtask

  initial begin
    int busy_cycles;
    int ready_cycles;
    logic [31:0] base;

    // Post-reset clear: busy for exactly MD cycles, then ready.
    apply_stimulus(0, 16'h0, '0, 0, 16'h0, 0, 1);
    apply_stimulus(0, 16'h0, '0, 0, 16'h0, 0, 1);
    check_val("reset_rd_data", rd_data, '0);
    check_val("reset_count", event_count, 32'd0);
    apply_stimulus(0, 16'h0, '0, 0, 16'h0, 0, 0);
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!clear_busy) break;
      busy_cycles++;
      idle(1);
    end
    check_val("clear_cycles", busy_cycles, MD);
    check_val("ready_after_clear", ready_for_new_event, 1'b1);
    read_all();

    // Basic write and readback.
    apply_stimulus(1, 16'h0102, 22'h00ABCD, 0, 16'h0, 0, 0);
    apply_stimulus(1, 16'h0003, 22'h3FFFFF, 0, 16'h0, 0, 0);
    idle(4);
    check_val("basic_count", event_count, 32'd2);
    apply_stimulus(0, 16'h0, '0, 1, 16'h0102, 0, 0);
    apply_stimulus(0, 16'h0, '0, 1, 16'h0003, 0, 0);
    idle(2);

    // Backpressure: readback holds the port so the FIFO only fills.
    base = m_cnt;
    ready_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1, 16'($urandom), DW'($urandom), 1, 16'($urandom), 0, 0);
      if (ready_for_new_event) ready_cycles++;
    end
    check_val("bp_ready_cycles", ready_cycles, 14);
    check_val("bp_ready_low", ready_for_new_event, 1'b0);
    idle(25);
    check_val("bp_overflow", overflow_err, 1'b1);
    check_val("bp_count", event_count, base + 32'd15);
    read_all();

    // Overwrite: last event to an address wins.
    base = m_cnt;
    apply_stimulus(1, 16'h0005, 22'd7, 0, 16'h0, 0, 0);
    apply_stimulus(1, 16'h0005, 22'd9, 0, 16'h0, 0, 0);
    idle(4);
    check_val("ovw_count", event_count, base + 32'd2);
    apply_stimulus(0, 16'h0, '0, 1, 16'h0005, 0, 0);
    idle(2);

    // Clear with events still queued.
    for (int i = 0; i < 5; i++)
      apply_stimulus(1, 16'($urandom), DW'($urandom), 1, 16'h0, 0, 0);
    apply_stimulus(0, 16'h0, '0, 0, 16'h0, 1, 0);
    idle(1);
    check_val("clr_busy", clear_busy, 1'b1);
    wait_clear_done("clr_done");
    check_val("clr_count", event_count, 32'd0);
    check_val("clr_overflow", overflow_err, 1'b0);
    read_all();

    // Reset while events are queued.
    for (int i = 0; i < 6; i++)
      apply_stimulus(1, 16'($urandom), DW'($urandom), 1, 16'h0, 0, 0);
    apply_stimulus(0, 16'h0, '0, 0, 16'h0, 0, 1);
    apply_stimulus(0, 16'h0, '0, 0, 16'h0, 0, 0);
    check_val("rst_ready", ready_for_new_event, 1'b0);
    check_val("rst_busy", clear_busy, 1'b1);
    check_val("rst_count", event_count, 32'd0);
    wait_clear_done("rst_done");
    idle(4);
    check_val("rst_no_drain", event_count, 32'd0);
    read_all();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus(($urandom_range(0, 1) == 1), 16'($urandom), DW'($urandom),
                     ($urandom_range(0, 4) == 0), 16'($urandom),
                     ($urandom_range(0, 99) == 0), ($urandom_range(0, 499) == 0));
    end
    idle(2);
    wait_clear_done("rand_done");
    idle(20);
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
